// File: rtl/fetch_thread_scheduler.sv
// Multithreaded fetch front end: per-thread PCs, round-robin thread pick, miss parking
// and branch redirects, driving the i-cache request and the pr_i2d pc/thread_id.
module fetch_thread_scheduler #(
   parameter int unsigned NUM_THREADS      = 2,
   parameter int unsigned TID_W            = $clog2(NUM_THREADS),
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter logic [31:0] THREAD_PC_STRIDE = 32'h0010_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_stall,
   input  logic [NUM_THREADS-1:0] i_thread_enable,
   input  logic                   i_inst_valid,
   input  logic                   i_miss,
   input  logic                   i_fill_done,
   input  logic [TID_W-1:0]       i_fill_thread,
   input  logic                   i_redirect_valid,
   input  logic [TID_W-1:0]       i_redirect_thread,
   input  logic [31:0]            i_redirect_pc,
   output logic                   o_valid,
   output logic [31:0]            o_pc,
   output logic [TID_W-1:0]       o_thread_id,
   output logic [NUM_THREADS-1:0] o_blocked
);

   typedef enum logic {
      RUN    = 1'b0,
      PARKED = 1'b1
   } thr_state_e;

   logic [TID_W-1:0]                  cur;
   logic [TID_W-1:0]                  nxt_cur;
   logic [TID_W-1:0]                  cand;
   logic                              found;
   logic [NUM_THREADS-1:0][31:0]      pc_all;
   logic [NUM_THREADS-1:0]            blocked;
   logic [NUM_THREADS-1:0]            blk_nxt;
   logic [NUM_THREADS-1:0]            elig;
   logic [NUM_THREADS-1:0]            sched;
   logic                              elig_cur;
   logic                              fire;
   logic                              accept;
   logic                              miss_fire;
   logic                              advance;
   logic [31:0]                       redir_pc;

   assign redir_pc  = i_redirect_pc & ~32'h0000_0003;
   assign elig      = i_thread_enable & ~blocked;
   assign elig_cur  = elig[cur];
   assign fire      = elig_cur & ~i_stall;
   assign accept    = fire & i_inst_valid;
   assign miss_fire = fire & i_miss;
   // An idle (ineligible) pointer moves on even without a fetch, so it never sticks.
   assign advance   = ~i_stall & (~elig_cur | i_inst_valid | i_miss);
   // Pick among threads as they will be after this cycle's miss/fill updates.
   assign sched     = i_thread_enable & ~blk_nxt;

   for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
      thr_state_e  st;
      logic [31:0] pc_q;
      logic        mine_cur;
      logic        park;
      logic        unpark;

      assign mine_cur   = (cur == TID_W'(t));
      assign park       = miss_fire & mine_cur;
      assign unpark     = i_fill_done & (i_fill_thread == TID_W'(t));
      assign blocked[t] = (st == PARKED);
      assign blk_nxt[t] = park | (blocked[t] & ~unpark);
      assign pc_all[t]  = pc_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st   <= RUN;
            pc_q <= RESET_PC + THREAD_PC_STRIDE * 32'(t);
         end else begin
            if (i_redirect_valid && (i_redirect_thread == TID_W'(t))) begin
               pc_q <= redir_pc;
            end else if (accept && mine_cur) begin
               pc_q <= pc_q + 32'd4;
            end
            case (st)
               RUN:     if (park) st <= PARKED;
               PARKED:  if (unpark) st <= RUN;
               default: st <= RUN;
            endcase
         end
      end
   end

   // Scan cur+1 .. cur+NUM_THREADS so the current thread is the last choice.
   always_comb begin
      nxt_cur = cur;
      found   = 1'b0;
      cand    = cur;
      for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
         cand = TID_W'((32'(cur) + k) % NUM_THREADS);
         if (!found && sched[cand]) begin
            found   = 1'b1;
            nxt_cur = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= '0;
      end else if (advance) begin
         cur <= nxt_cur;
      end
   end

   assign o_valid     = elig_cur;
   assign o_pc        = pc_all[cur];
   assign o_thread_id = cur;
   assign o_blocked   = blocked;

   a_hit_miss_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_inst_valid && i_miss));

endmodule
